// File: rtl/i2c_slave_bit_sequencer.sv
// Bit-level sequencer for the I2C slave: drives the shared bit counter, shifts
// in bytes MSB-first and runs the 9th-bit ACK/NACK phase.
module i2c_slave_bit_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             FPGA_clk,
  input  logic             rst,
  input  logic             scl_rise,
  input  logic             scl_fall,
  input  logic             start_det,
  input  logic             stop_det,
  input  logic             sda_in,
  input  logic             ack_en,
  input  logic [WIDTH-1:0] count,
  output logic             cnt_enable,
  output logic             cnt_rst,
  output logic [7:0]       rx_byte,
  output logic             byte_valid,
  output logic             sda_drive_low,
  output logic             ack_phase,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, DATA, ACK, HOLD} state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] shift_reg;
  logic       ack_latched;
  logic       rise_only;
  logic       fall_only;
  logic       byte_done;
  logic       ack_done;

  // Handshake-free pulse interface: every input pulse is valid for exactly one
  // cycle and is consumed in that cycle; there is no back-pressure.
  always_comb begin
    state_next = state;
    // Simultaneous rise and fall is a glitch and is treated as no SCL event.
    rise_only  = scl_rise & ~scl_fall;
    fall_only  = scl_fall & ~scl_rise;
    byte_done  = (state == DATA) && fall_only && (count == WIDTH'(8)) &&
                 !start_det && !stop_det;
    ack_done   = (state == ACK) && fall_only && !start_det && !stop_det;

    if (stop_det) begin
      state_next = IDLE;
    end else if (start_det) begin
      state_next = DATA;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        DATA:    if (byte_done) state_next = ACK;
        ACK:     if (ack_done) state_next = ack_latched ? DATA : HOLD;
        HOLD:    state_next = HOLD;
        default: state_next = IDLE;
      endcase
    end

    cnt_rst    = rst | (state == IDLE) | start_det | stop_det | byte_done;
    cnt_enable = (state == DATA) & rise_only & ~cnt_rst;
    ack_phase  = (state == ACK);
    busy       = (state != IDLE);
  end

  always_ff @(posedge FPGA_clk) begin
    if (rst) begin
      state         <= IDLE;
      shift_reg     <= 8'h00;
      rx_byte       <= 8'h00;
      byte_valid    <= 1'b0;
      sda_drive_low <= 1'b0;
      ack_latched   <= 1'b0;
    end else begin
      state      <= state_next;
      byte_valid <= byte_done;
      if (stop_det) begin
        sda_drive_low <= 1'b0;
      end else if (start_det) begin
        shift_reg     <= 8'h00;
        sda_drive_low <= 1'b0;
      end else begin
        if (cnt_enable) shift_reg <= {shift_reg[6:0], sda_in};
        if (byte_done) begin
          rx_byte       <= shift_reg;
          ack_latched   <= ack_en;
          sda_drive_low <= ack_en;
        end
        if (ack_done) sda_drive_low <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_bit_sequencer.sv
// Bench for i2c_slave_bit_sequencer: closes the loop with a bit counter and
// compares against a queue-based bus-level model plus a short hand-derived table.
module tb_i2c_slave_bit_sequencer;
  localparam int WIDTH = 4;
  localparam int M_IDLE = 0, M_RX = 1, M_ACK = 2, M_HOLD = 3;

  logic             clk = 1'b0;
  logic             rst, scl_rise, scl_fall, start_det, stop_det, sda_in, ack_en;
  logic [WIDTH-1:0] count;
  logic             cnt_enable, cnt_rst, byte_valid, sda_drive_low, ack_phase, busy;
  logic [7:0]       rx_byte;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  // bus-level model: received bits of the current byte, mode, last byte
  int         m_mode;
  int         m_bits[$];
  logic [7:0] m_rx;
  logic       m_drive, m_ack, m_bv;

  typedef struct {
    logic r, f, st, sp, sda;
    logic [3:0] cnt;
    logic bv;
    logic [7:0] rx;
    logic drive, ackph, busy;
  } vec_t;
  vec_t tbl[11];

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (cnt_rst) count <= '0;
    else if (cnt_enable) count <= count + 1'b1;
  end

  i2c_slave_bit_sequencer #(.WIDTH(WIDTH)) dut (
    .FPGA_clk(clk), .rst(rst), .scl_rise(scl_rise), .scl_fall(scl_fall),
    .start_det(start_det), .stop_det(stop_det), .sda_in(sda_in), .ack_en(ack_en),
    .count(count), .cnt_enable(cnt_enable), .cnt_rst(cnt_rst), .rx_byte(rx_byte),
    .byte_valid(byte_valid), .sda_drive_low(sda_drive_low), .ack_phase(ack_phase),
    .busy(busy)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] bits_value();
    int acc = 0;
    foreach (m_bits[i]) acc = acc * 2 + m_bits[i];
    return acc[7:0];
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_bits.delete(); m_rx = 8'h00;
    m_drive = 1'b0; m_ack = 1'b0; m_bv = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic r, f, st, sp, sda, ack);
    m_bv = 1'b0;
    if (sp) begin
      m_mode = M_IDLE; m_drive = 1'b0; m_bits.delete();
    end else if (st) begin
      m_mode = M_RX; m_drive = 1'b0; m_bits.delete();
    end else if (!(r && f)) begin
      if (m_mode == M_RX) begin
        if (r) m_bits.push_back(int'(sda));
        else if (f && m_bits.size() == 8) begin
          m_rx = bits_value(); m_bv = 1'b1; exp_q.push_back(m_rx);
          m_ack = ack; m_drive = ack; m_mode = M_ACK; m_bits.delete();
        end
      end else if (m_mode == M_ACK && f) begin
        m_drive = 1'b0;
        m_mode = m_ack ? M_RX : M_HOLD;
      end
    end
  endtask

  task automatic set_idle();
    scl_rise = 0; scl_fall = 0; start_det = 0; stop_det = 0; sda_in = 0;
  endtask

  // one bus event followed by one quiet cycle
  task automatic drive_event(input logic r, f, st, sp, sda, ack);
    logic exp_rst, exp_en;
    @(negedge clk);
    check("byte_valid_width", byte_valid, 1'b0);
    scl_rise = r; scl_fall = f; start_det = st; stop_det = sp; sda_in = sda; ack_en = ack;
    #1;
    exp_rst = (m_mode == M_IDLE) || st || sp || (m_mode == M_RX && f && !r && m_bits.size() == 8);
    exp_en  = (m_mode == M_RX) && r && !f && !exp_rst;
    check("cnt_rst", cnt_rst, exp_rst);
    check("cnt_enable", cnt_enable, exp_en);
    model_step(r, f, st, sp, sda, ack);
    @(posedge clk);
    @(negedge clk);
    set_idle();
    #1;
    if (byte_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard: unexpected byte %0h", rx_byte);
      end else begin
        check("scoreboard_rx", rx_byte, exp_q.pop_front());
      end
    end
  endtask

  task automatic check_model();
    check("count", count, m_bits.size());
    check("byte_valid", byte_valid, m_bv);
    check("rx_byte", rx_byte, m_rx);
    check("sda_drive_low", sda_drive_low, m_drive);
    check("ack_phase", ack_phase, m_mode == M_ACK);
    check("busy", busy, m_mode != M_IDLE);
  endtask

  task automatic ev(input logic r, f, st, sp, sda, ack);
    drive_event(r, f, st, sp, sda, ack);
    check_model();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ack);
    for (int i = 7; i >= 0; i--) begin
      ev(1, 0, 0, 0, b[i], ack);
      ev(0, 1, 0, 0, 0, ack);
    end
    ev(1, 0, 0, 0, 1, ack);
    ev(0, 1, 0, 0, 0, ack);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; set_idle(); ack_en = 0;
    repeat (3) @(negedge clk);
    #1;
    model_reset();
    check("rst_cnt_rst", cnt_rst, 1'b1);
    check("rst_cnt_enable", cnt_enable, 1'b0);
    check_model();
    rst = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1; set_idle(); ack_en = 0;
    model_reset();
    // r f st sp sda | cnt bv rx drive ackph busy
    tbl[0]  = '{1, 0, 0, 0, 1, 4'd0, 0, 8'h00, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 4'd0, 0, 8'h00, 0, 0, 0};
    tbl[2]  = '{0, 0, 1, 0, 0, 4'd0, 0, 8'h00, 0, 0, 1};
    tbl[3]  = '{1, 0, 0, 0, 1, 4'd1, 0, 8'h00, 0, 0, 1};
    tbl[4]  = '{0, 1, 0, 0, 0, 4'd1, 0, 8'h00, 0, 0, 1};
    tbl[5]  = '{1, 0, 0, 0, 0, 4'd2, 0, 8'h00, 0, 0, 1};
    tbl[6]  = '{1, 1, 0, 0, 1, 4'd2, 0, 8'h00, 0, 0, 1};
    tbl[7]  = '{0, 0, 1, 1, 0, 4'd0, 0, 8'h00, 0, 0, 0};
    tbl[8]  = '{0, 0, 1, 0, 0, 4'd0, 0, 8'h00, 0, 0, 1};
    tbl[9]  = '{1, 0, 0, 0, 1, 4'd1, 0, 8'h00, 0, 0, 1};
    tbl[10] = '{0, 0, 0, 1, 0, 4'd0, 0, 8'h00, 0, 0, 0};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      drive_event(tbl[i].r, tbl[i].f, tbl[i].st, tbl[i].sp, tbl[i].sda, 1'b1);
      check($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
      check($sformatf("tbl%0d_byte_valid", i), byte_valid, tbl[i].bv);
      check($sformatf("tbl%0d_rx_byte", i), rx_byte, tbl[i].rx);
      check($sformatf("tbl%0d_sda_drive_low", i), sda_drive_low, tbl[i].drive);
      check($sformatf("tbl%0d_ack_phase", i), ack_phase, tbl[i].ackph);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
    end

    // ACKed byte, then two back-to-back bytes
    ev(0, 0, 1, 0, 0, 1);
    send_byte(8'hA5, 1);
    check("after_a5_rx", rx_byte, 8'hA5);
    send_byte(8'h3C, 1);
    send_byte(8'hC3, 1);
    check("after_c3_rx", rx_byte, 8'hC3);
    ev(0, 0, 0, 1, 0, 1);

    // NACKed byte, ignored SCL in HOLD, then a fresh START
    ev(0, 0, 1, 0, 0, 0);
    send_byte(8'hFF, 0);
    for (int i = 0; i < 9; i++) begin
      ev(1, 0, 0, 0, 1, 1);
      ev(0, 1, 0, 0, 0, 1);
    end
    ev(0, 0, 1, 0, 0, 1);
    send_byte(8'h12, 1);
    check("after_12_rx", rx_byte, 8'h12);

    // repeated START after 3 bits
    ev(0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin ev(1, 0, 0, 0, 1, 1); ev(0, 1, 0, 0, 0, 1); end
    ev(0, 0, 1, 0, 0, 1);
    send_byte(8'h81, 1);
    check("after_81_rx", rx_byte, 8'h81);

    // STOP after 5 bits, glitch mid-byte, reset mid-byte
    for (int i = 0; i < 5; i++) begin ev(1, 0, 0, 0, 0, 1); ev(0, 1, 0, 0, 0, 1); end
    ev(0, 0, 0, 1, 0, 1);
    ev(0, 0, 1, 0, 0, 1);
    ev(1, 0, 0, 0, 1, 1); ev(0, 1, 0, 0, 0, 1);
    ev(1, 1, 0, 0, 1, 1);
    ev(0, 0, 1, 1, 0, 1);
    ev(0, 0, 1, 0, 0, 1);
    ev(1, 0, 0, 0, 1, 1); ev(0, 1, 0, 0, 0, 1);
    do_reset();

    // randomized bus traffic
    for (int n = 0; n < 600; n++) begin
      k = $urandom_range(0, 39);
      if (k == 0) ev(0, 0, 1, 0, 0, 1'($urandom_range(0, 1)));
      else if (k == 1) ev(0, 0, 0, 1, 0, 1'($urandom_range(0, 1)));
      else if (k == 2) ev(0, 0, 1, 1, 0, 1'($urandom_range(0, 1)));
      else if (k == 3) ev(1, 1, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else if (k == 4) do_reset();
      else begin
        ev(1, 0, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        ev(0, 1, 0, 0, 0, 1'($urandom_range(0, 3) != 0));
      end
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/i2c_slave_bit_sequencer.md
Name: i2c_slave_bit_sequencer

Overview:
Sequences the shared bit counter (`counter`, WIDTH param) inside the I2C slave. It uses synchronized SCL/SDA edge pulses and START/STOP detect pulses to drive the counter's enable and reset inputs. From the returned count it assembles received bytes MSB-first and runs the 9th-bit ACK phase. It sits between the bus synchronizer/edge detector and the slave's address/register logic.

Parameters:
WIDTH, 4, width of the bit counter driven by this block; must be >= 4 so count 8 is representable.

Ports:
FPGA_clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
scl_rise  in  1  one-cycle pulse on synchronized SCL rising edge
scl_fall  in  1  one-cycle pulse on synchronized SCL falling edge
start_det  in  1  one-cycle pulse on START or repeated START
stop_det  in  1  one-cycle pulse on STOP
sda_in  in  1  synchronized SDA level
ack_en  in  1  slave ACKs the current byte when high; sampled at the 8th scl_fall
count  in  WIDTH  current value from bit counter
cnt_enable  out  1  counter enable (combinational)
cnt_rst  out  1  counter reset (combinational)
rx_byte  out  8  last completed byte
byte_valid  out  1  one-cycle pulse when rx_byte updates
sda_drive_low  out  1  slave pulls SDA low (ACK)
ack_phase  out  1  high while in ACK state
busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, DATA, ACK, HOLD.
- Event priority: rst > stop_det > start_det > SCL events.
- Reset values: state IDLE, shift register 0, rx_byte 0x00, byte_valid 0, sda_drive_low 0, ack_phase 0, busy 0, cnt_enable 0, cnt_rst 1.
- cnt_rst = rst OR state==IDLE OR start_det OR stop_det OR (DATA-to-ACK transition cycle).
- cnt_enable = state==DATA AND scl_rise AND NOT scl_fall AND NOT cnt_rst. The counter therefore increments the cycle after each data-bit rising edge.
- IDLE:
  - start_det -> DATA.
  - All SCL activity ignored.
- DATA:
  - On scl_rise: shift register <= {shift[6:0], sda_in}; pulse cnt_enable.
  - On scl_fall with count==8:
    - rx_byte <= shift register; byte_valid = 1 next cycle only.
    - Latch ack_en; sda_drive_low <= ack_en.
    - Pulse cnt_rst; -> ACK.
  - scl_fall with count<8: no action.
- ACK:
  - ack_phase = 1.
  - scl_rise: no action (master samples ACK).
  - Next scl_fall: sda_drive_low <= 0; -> DATA if the latched ack was 1, else -> HOLD.
  - Counter holds 0 throughout.
- HOLD (after NACK):
  - SCL ignored, counter held.
  - start_det -> DATA; stop_det -> IDLE.
- Any state:
  - stop_det -> IDLE, sda_drive_low <= 0.
  - start_det (repeated START) -> DATA, shift register cleared, sda_drive_low <= 0, counter reset.
  - rx_byte retained in both cases.
- start_det and stop_det in the same cycle: stop wins -> IDLE.
- scl_rise and scl_fall in the same cycle: protocol glitch; both ignored, no shift, no count change.
- rst mid-byte: everything returns to reset values next cycle; the partial byte is discarded.
- byte_valid is asserted exactly one cycle per completed byte, including NACKed bytes.
- rx_byte is held until the next completed byte.

Test Plan:
1. Hold rst 3 cycles -> all outputs at reset values and count==0; SCL pulses in IDLE leave count 0.
2. START, bits of 0xA5 MSB-first, ack_en=1:
   - count steps 0..8.
   - On the 8th fall, a single byte_valid pulse with rx_byte=0xA5.
   - sda_drive_low high from the 8th to the 9th fall.
   - count back to 0, state DATA.
3. START, bytes 0x3C then 0xC3, ack_en=1 -> exactly two byte_valid pulses with the correct rx_byte values; ack_phase high during each 9th bit.
4. START, byte 0xFF with ack_en=0:
   - byte_valid pulses; sda_drive_low never asserts.
   - Following 9 SCL pulses produce no count change and no byte_valid.
   - A new START then byte 0x12 is received correctly.
5. START, 3 bits, repeated START, byte 0x81 -> count cleared at start_det and rx_byte=0x81 (no stale bits).
6. Edge cases:
   - STOP after 5 bits -> IDLE, busy 0, no byte_valid.
   - start_det+stop_det in the same cycle -> IDLE.
   - scl_rise+scl_fall in the same cycle during DATA -> count and shift unchanged.
